// File: rtl/register_delay_line_pkg.sv
// rtl/register_delay_line_pkg.sv - shared defaults for the programmable sample-delay line
package register_delay_line_pkg;

    localparam int DEF_D = 7;
    localparam int DEF_A = 3;

    // The fill counter must be able to hold R = 2**A itself.
    function automatic int fill_width(input int a);
        return a + 1;
    endfunction

endpackage

// File: rtl/register_delay_line_delay_entry.sv
// rtl/register_delay_line_delay_entry.sv - one buffer slot: sample register plus its valid flag
module register_delay_line_delay_entry
    import register_delay_line_pkg::*;
#(
    parameter int D = DEF_D
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         we,
    input  logic         flush,
    input  logic [D-1:0] d,
    output logic [D-1:0] q,
    output logic         valid
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (we) begin
            q <= d;
        end
    end

    // Flush only clears the flag; the stored sample stays but becomes unreachable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (we) begin
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/register_delay_line.sv
// rtl/register_delay_line.sv - circular-buffer delay line with runtime-selectable tap
module register_delay_line
    import register_delay_line_pkg::*;
#(
    parameter int D = DEF_D,
    parameter int A = DEF_A,
    parameter int R = 2 ** A
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [D-1:0]              data,
    input  logic [A-1:0]              delay,
    input  logic                      flush,
    output logic [D-1:0]              out,
    output logic                      out_valid,
    output logic [R-1:0]              entry_valid,
    output logic [fill_width(A)-1:0]  fill
);

    localparam int               FW       = fill_width(A);
    localparam logic [FW-1:0]    FILL_MAX = FW'(R);

    logic [A-1:0] wr_ptr;
    logic [A-1:0] rd_idx;
    logic         wr_en;
    logic [R-1:0] we_vec;
    logic [D-1:0] mem_q [R];

    // A flush on the same edge as a write discards that sample.
    assign wr_en = in_valid & ~flush;

    always_comb begin
        we_vec = '0;
        if (wr_en) begin
            we_vec[wr_ptr] = 1'b1;
        end
    end

    for (genvar i = 0; i < R; i++) begin : g_entry
        register_delay_line_delay_entry #(
            .D(D)
        ) u_entry (
            .clk   (clk),
            .rst   (rst),
            .we    (we_vec[i]),
            .flush (flush),
            .d     (data),
            .q     (mem_q[i]),
            .valid (entry_valid[i])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            fill   <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            fill   <= '0;
        end else if (in_valid) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (fill != FILL_MAX) begin
                fill <= fill + 1'b1;
            end
        end
    end

    // wr_ptr already points one past the newest sample, so delay=1 selects it.
    assign rd_idx    = wr_ptr - delay;
    assign out_valid = (delay != '0) && entry_valid[rd_idx];
    assign out       = out_valid ? mem_q[rd_idx] : '0;

endmodule

// File: tb/tb_register_delay_line.sv
// tb/tb_register_delay_line.sv - self-checking bench for register_delay_line
module tb_register_delay_line;

    localparam int D = 7;
    localparam int A = 3;
    localparam int R = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         flush = 1'b0;
    logic [D-1:0] data = '0;
    logic [A-1:0] delay = '0;
    logic [D-1:0] out;
    logic         out_valid;
    logic [R-1:0] entry_valid;
    logic [A:0]   fill;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: samples written since the last flush/reset, newest at the back.
    logic [D-1:0] hist[$];
    int           n_wr = 0;

    always #5 clk = ~clk;

    register_delay_line #(.D(D), .A(A), .R(R)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .data        (data),
        .delay       (delay),
        .flush       (flush),
        .out         (out),
        .out_valid   (out_valid),
        .entry_valid (entry_valid),
        .fill        (fill)
    );

    function automatic int m_fill();
        return (n_wr < R) ? n_wr : R;
    endfunction

    function automatic logic m_valid(input int d);
        return (d != 0) && (d <= m_fill());
    endfunction

    function automatic logic [D-1:0] m_out(input int d);
        if (!m_valid(d)) return '0;
        return hist[hist.size() - d];
    endfunction

    function automatic logic [R-1:0] m_ev();
        logic [R-1:0] v;
        v = '0;
        for (int i = 0; i < m_fill(); i++) v[i] = 1'b1;
        return v;
    endfunction

    task automatic model_clear();
        hist.delete();
        n_wr = 0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs after the falling edge, update the model on the rising edge.
    task automatic step(input logic iv, input logic fl, input logic [D-1:0] v);
        @(negedge clk);
        #1;
        in_valid = iv;
        flush    = fl;
        data     = v;
        @(posedge clk);
        if (rst) begin
            if (fl) begin
                model_clear();
            end else if (iv) begin
                hist.push_back(v);
                if (hist.size() > R) void'(hist.pop_front());
                n_wr++;
            end
        end
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic wr(input logic [D-1:0] v);
        step(1'b1, 1'b0, v);
    endtask

    task automatic set_delay(input int d);
        @(negedge clk);
        #1;
        delay = A'(d);
        #1;
    endtask

    // Continuous comparison against the model on every falling edge.
    always @(negedge clk) begin
        chk("cyc_out_valid", 32'(out_valid), 32'(m_valid(int'(delay))));
        if (m_valid(int'(delay)) || delay == '0)
            chk("cyc_out", 32'(out), 32'(m_out(int'(delay))));
        chk("cyc_fill", 32'(fill), 32'(m_fill()));
        chk("cyc_entry_valid", 32'(entry_valid), 32'(m_ev()));
    end

    initial begin
        #2;
        chk("rst_out", 32'(out), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_fill", 32'(fill), 32'h0);
        chk("rst_entry_valid", 32'(entry_valid), 32'h0);
        @(negedge clk);
        #1 rst = 1'b1;

        // Reset mid-stream, asserted between edges.
        for (int i = 1; i <= 5; i++) wr(D'(i));
        set_delay(2);
        chk("pre_rst_out", 32'(out), 32'h4);
        @(posedge clk);
        #2;
        rst = 1'b0;
        model_clear();
        #1;
        chk("async_rst_out", 32'(out), 32'h0);
        chk("async_rst_out_valid", 32'(out_valid), 32'h0);
        chk("async_rst_fill", 32'(fill), 32'h0);
        chk("async_rst_entry_valid", 32'(entry_valid), 32'h0);
        @(negedge clk);
        #1 rst = 1'b1;

        // Basic delay
        wr(7'h11);
        wr(7'h22);
        wr(7'h33);
        set_delay(1);
        chk("basic_d1_out", 32'(out), 32'h33);
        chk("basic_d1_valid", 32'(out_valid), 32'h1);
        chk("basic_fill", 32'(fill), 32'h3);
        set_delay(3);
        chk("basic_d3_out", 32'(out), 32'h11);
        chk("basic_d3_valid", 32'(out_valid), 32'h1);
        set_delay(4);
        chk("basic_d4_valid", 32'(out_valid), 32'h0);
        chk("basic_fill2", 32'(fill), 32'h3);

        // Wrap and saturation
        for (int i = 1; i <= 10; i++) wr(D'(i));
        set_delay(7);
        chk("wrap_out", 32'(out), 32'h4);
        chk("wrap_valid", 32'(out_valid), 32'h1);
        chk("wrap_fill", 32'(fill), 32'h8);
        chk("wrap_entry_valid", 32'(entry_valid), 32'hFF);
        set_delay(0);
        chk("zero_tap_full_out", 32'(out), 32'h0);
        chk("zero_tap_full_valid", 32'(out_valid), 32'h0);

        // Flush beats a simultaneous write
        step(1'b1, 1'b1, 7'h55);
        chk("flush_fill", 32'(fill), 32'h0);
        chk("flush_entry_valid", 32'(entry_valid), 32'h0);
        for (int d = 0; d < R; d++) begin
            delay = A'(d);
            #1;
            chk("flush_out_valid", 32'(out_valid), 32'h0);
        end
        wr(7'h66);
        set_delay(1);
        chk("post_flush_out", 32'(out), 32'h66);
        chk("post_flush_entry_valid", 32'(entry_valid), 32'h01);
        set_delay(0);
        chk("zero_tap_out", 32'(out), 32'h0);
        chk("zero_tap_valid", 32'(out_valid), 32'h0);

        // Gapped input: delay counts samples, not cycles
        step(1'b0, 1'b1, '0);
        wr(7'h01);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0);
        wr(7'h02);
        set_delay(2);
        chk("gap_out", 32'(out), 32'h01);
        chk("gap_valid", 32'(out_valid), 32'h1);

        // Mixed stream with tap changes, checked by the per-cycle comparison
        for (int i = 0; i < 40; i++) begin
            step(((i % 3) != 1), (i == 25), D'(i * 13 + 5));
            set_delay((i * 5) % R);
        end

        @(negedge clk);
        #2;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
